// File: rtl/mnacidpro_seq.sv
`timescale 1ns/1ps
// mnacidpro_seq -- nucleic-acid prep sequencer.
// Walks a bead-based extraction protocol (load, lysis, wash, elute) by
// driving a valve bank and a three-valve peristaltic pump. Elution repeats
// once per collect channel so each outlet receives its own fraction.
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   start                begin protocol (only honoured in IDLE)
//   abort                terminate protocol from any non-IDLE state
//   t_load..t_elute      phase lengths in pump strokes, 0 skips the phase
//   valve[10:0]          1 = closed; bit order lysis, wash, elute, dead_end,
//                        vertical, horiz, waste, bead, loop_exit, bead_trap,
//                        collect
//   pump[2:0]            peristaltic valve pattern
//   collect_sel[SIZE-1:0] one-hot active outlet during ELUTE
//   busy, done, aborted  status; state = current FSM state
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | waiting for start, everything closed, pump off
// LOAD  | pull sample over the bead trap to waste
// LYSIS | lysis buffer through vertical path to waste
// WASH  | wash buffer through horizontal path to waste
// ELUTE | elution buffer to collect outlet, once per channel
// DONE  | one-cycle completion pulse, then back to IDLE
module mnacidpro_seq #(
  parameter int SIZE     = 5,
  parameter int PUMP_DIV = 8,
  parameter int STEP_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [STEP_W-1:0] t_load,
  input  logic [STEP_W-1:0] t_lysis,
  input  logic [STEP_W-1:0] t_wash,
  input  logic [STEP_W-1:0] t_elute,
  output logic [10:0]       valve,
  output logic [2:0]        pump,
  output logic [SIZE-1:0]   collect_sel,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [2:0]        state
);

  localparam int CH_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_LYSIS = 3'd2;
  localparam logic [2:0] S_WASH  = 3'd3;
  localparam logic [2:0] S_ELUTE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [7:0]      DIV_LAST = 8'(PUMP_DIV - 1);
  localparam logic [CH_W-1:0] CH_LAST  = CH_W'(SIZE - 1);

  localparam int V_LYSIS     = 0;
  localparam int V_WASH      = 1;
  localparam int V_ELUTE     = 2;
  localparam int V_VERTICAL  = 4;
  localparam int V_HORIZ     = 5;
  localparam int V_WASTE     = 6;
  localparam int V_BEAD      = 7;
  localparam int V_LOOP_EXIT = 8;
  localparam int V_BEAD_TRAP = 9;
  localparam int V_COLLECT   = 10;

  localparam logic [10:0] ALL_CLOSED = 11'h7FF;
  localparam logic [10:0] OPEN_LOAD  = (11'd1 << V_BEAD) | (11'd1 << V_BEAD_TRAP) |
                                       (11'd1 << V_WASTE);
  localparam logic [10:0] OPEN_LYSIS = (11'd1 << V_LYSIS) | (11'd1 << V_VERTICAL) |
                                       (11'd1 << V_BEAD_TRAP) | (11'd1 << V_WASTE);
  localparam logic [10:0] OPEN_WASH  = (11'd1 << V_WASH) | (11'd1 << V_HORIZ) |
                                       (11'd1 << V_BEAD_TRAP) | (11'd1 << V_WASTE);
  localparam logic [10:0] OPEN_ELUTE = (11'd1 << V_ELUTE) | (11'd1 << V_LOOP_EXIT) |
                                       (11'd1 << V_BEAD_TRAP) | (11'd1 << V_COLLECT);

  localparam logic [2:0] PUMP_FIRST = 3'b110;

  // First phase strictly after cur whose duration is nonzero; DONE if none.
  function automatic logic [2:0] next_phase(
    input logic [2:0]        cur,
    input logic [STEP_W-1:0] dl,
    input logic [STEP_W-1:0] dy,
    input logic [STEP_W-1:0] dw,
    input logic [STEP_W-1:0] de
  );
    logic [2:0] nxt;
    nxt = S_DONE;
    if (cur < S_ELUTE && de != '0) nxt = S_ELUTE;
    if (cur < S_WASH  && dw != '0) nxt = S_WASH;
    if (cur < S_LYSIS && dy != '0) nxt = S_LYSIS;
    if (cur < S_LOAD  && dl != '0) nxt = S_LOAD;
    return nxt;
  endfunction

  logic [2:0]        r_state;
  logic [7:0]        r_div;
  logic [STEP_W-1:0] r_strokes;
  logic [CH_W-1:0]   r_ch;
  logic [STEP_W-1:0] r_dur_load;
  logic [STEP_W-1:0] r_dur_lysis;
  logic [STEP_W-1:0] r_dur_wash;
  logic [STEP_W-1:0] r_dur_elute;
  logic [10:0]       r_valve;
  logic [2:0]        r_pump;
  logic [SIZE-1:0]   r_collect;
  logic              r_busy;
  logic              r_done;
  logic              r_aborted;

  logic              w_active;
  logic              w_tick;
  logic [STEP_W-1:0] w_cur_dur;
  logic              w_phase_end;
  logic              w_last_ch;
  logic              w_start_ok;
  logic [2:0]        w_state_nxt;
  logic              w_ch_adv;
  logic              w_enter;
  logic              w_nxt_active;
  logic [CH_W-1:0]   w_ch_nxt;
  logic [10:0]       w_valve_nxt;
  logic [2:0]        w_pump_nxt;
  logic [SIZE-1:0]   w_collect_nxt;

  assign w_active     = (r_state >= S_LOAD) && (r_state <= S_ELUTE);
  assign w_tick       = w_active && (r_div == DIV_LAST);
  assign w_phase_end  = w_tick && ((r_strokes + STEP_W'(1)) == w_cur_dur);
  assign w_last_ch    = (r_ch == CH_LAST);
  assign w_start_ok   = (r_state == S_IDLE) && start && !abort;
  // A channel change inside ELUTE restarts the stroke pattern like a state entry.
  assign w_enter      = (w_state_nxt != r_state) || w_ch_adv;
  assign w_nxt_active = (w_state_nxt >= S_LOAD) && (w_state_nxt <= S_ELUTE);
  assign w_ch_nxt     = (w_state_nxt == S_IDLE) ? '0 :
                        w_ch_adv ? (r_ch + CH_W'(1)) : r_ch;

  always_comb begin
    case (r_state)
      S_LOAD:  w_cur_dur = r_dur_load;
      S_LYSIS: w_cur_dur = r_dur_lysis;
      S_WASH:  w_cur_dur = r_dur_wash;
      S_ELUTE: w_cur_dur = r_dur_elute;
      default: w_cur_dur = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_ch_adv    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok)
          w_state_nxt = next_phase(S_IDLE, t_load, t_lysis, t_wash, t_elute);
      end
      S_LOAD, S_LYSIS, S_WASH, S_ELUTE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_phase_end) begin
          if (r_state == S_ELUTE && !w_last_ch)
            w_ch_adv = 1'b1;
          else
            w_state_nxt = next_phase(r_state, r_dur_load, r_dur_lysis,
                                     r_dur_wash, r_dur_elute);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, derived from the
  // next state so they line up with the state register.
  always_comb begin
    case (w_state_nxt)
      S_LOAD:  w_valve_nxt = ALL_CLOSED & ~OPEN_LOAD;
      S_LYSIS: w_valve_nxt = ALL_CLOSED & ~OPEN_LYSIS;
      S_WASH:  w_valve_nxt = ALL_CLOSED & ~OPEN_WASH;
      S_ELUTE: w_valve_nxt = ALL_CLOSED & ~OPEN_ELUTE;
      default: w_valve_nxt = ALL_CLOSED;
    endcase

    if (!w_nxt_active)
      w_pump_nxt = 3'b000;
    else if (w_enter)
      w_pump_nxt = PUMP_FIRST;
    else if (w_tick)
      w_pump_nxt = {r_pump[0], r_pump[2:1]};  // 110 -> 011 -> 101 -> 110
    else
      w_pump_nxt = r_pump;

    if (w_state_nxt == S_ELUTE)
      w_collect_nxt = SIZE'(1) << w_ch_nxt;
    else
      w_collect_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div       <= '0;
      r_strokes   <= '0;
      r_ch        <= '0;
      r_dur_load  <= '0;
      r_dur_lysis <= '0;
      r_dur_wash  <= '0;
      r_dur_elute <= '0;
    end else begin
      if (!w_nxt_active || w_enter || r_div == DIV_LAST) r_div <= '0;
      else                                               r_div <= r_div + 8'd1;

      if (!w_nxt_active || w_enter) r_strokes <= '0;
      else if (w_tick)              r_strokes <= r_strokes + STEP_W'(1);

      r_ch <= w_ch_nxt;

      if (w_start_ok) begin
        r_dur_load  <= t_load;
        r_dur_lysis <= t_lysis;
        r_dur_wash  <= t_wash;
        r_dur_elute <= t_elute;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valve   <= ALL_CLOSED;
      r_pump    <= 3'b000;
      r_collect <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_valve   <= w_valve_nxt;
      r_pump    <= w_pump_nxt;
      r_collect <= w_collect_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= (w_state_nxt == S_DONE);
      r_aborted <= abort && (r_state != S_IDLE);
    end
  end

  assign state       = r_state;
  assign valve       = r_valve;
  assign pump        = r_pump;
  assign collect_sel = r_collect;
  assign busy        = r_busy;
  assign done        = r_done;
  assign aborted     = r_aborted;

endmodule

// File: tb/tb_mnacidpro_seq.sv
`timescale 1ns/1ps
module tb_mnacidpro_seq;
  localparam int SIZE = 5;
  localparam int PD   = 8;
  localparam int SW   = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [SW-1:0]   t_load = '0;
  logic [SW-1:0]   t_lysis = '0;
  logic [SW-1:0]   t_wash = '0;
  logic [SW-1:0]   t_elute = '0;
  logic [10:0]     valve;
  logic [2:0]      pump;
  logic [SIZE-1:0] collect_sel;
  logic            busy;
  logic            done;
  logic            aborted;
  logic [2:0]      state;

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  mnacidpro_seq #(.SIZE(SIZE), .PUMP_DIV(PD), .STEP_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .t_load(t_load), .t_lysis(t_lysis), .t_wash(t_wash), .t_elute(t_elute),
    .valve(valve), .pump(pump), .collect_sel(collect_sel),
    .busy(busy), .done(done), .aborted(aborted), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [2:0]      st;
    logic [10:0]     valve;
    logic [2:0]      pump;
    logic [SIZE-1:0] col;
    logic            busy;
    logic            done;
    logic            aborted;
  } rec_t;

  rec_t q[$];
  rec_t cur;

  localparam int B_LYSIS = 0, B_WASH = 1, B_ELUTE = 2, B_VERTICAL = 4, B_HORIZ = 5;
  localparam int B_WASTE = 6, B_BEAD = 7, B_LOOP_EXIT = 8, B_BEAD_TRAP = 9, B_COLLECT = 10;

  function automatic rec_t idle_rec();
    rec_t r;
    r.st = 3'd0; r.valve = 11'h7FF; r.pump = 3'b000; r.col = '0;
    r.busy = 1'b0; r.done = 1'b0; r.aborted = 1'b0;
    return r;
  endfunction

  function automatic logic [10:0] valve_of(input int ph);
    logic [10:0] v;
    v = 11'h7FF;
    case (ph)
      1: begin v[B_BEAD] = 1'b0; v[B_BEAD_TRAP] = 1'b0; v[B_WASTE] = 1'b0; end
      2: begin v[B_LYSIS] = 1'b0; v[B_VERTICAL] = 1'b0; v[B_BEAD_TRAP] = 1'b0; v[B_WASTE] = 1'b0; end
      3: begin v[B_WASH] = 1'b0; v[B_HORIZ] = 1'b0; v[B_BEAD_TRAP] = 1'b0; v[B_WASTE] = 1'b0; end
      4: begin v[B_ELUTE] = 1'b0; v[B_LOOP_EXIT] = 1'b0; v[B_BEAD_TRAP] = 1'b0; v[B_COLLECT] = 1'b0; end
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [2:0] pat(input int i);
    case (i)
      0: return 3'b110;
      1: return 3'b011;
      default: return 3'b101;
    endcase
  endfunction

  // Expand a whole protocol into one record per clock cycle.
  task automatic build(input int d0, input int d1, input int d2, input int d3);
    int d[4];
    rec_t r;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int ph = 1; ph <= 4; ph++) begin
      if (d[ph-1] > 0) begin
        for (int c = 0; c < ((ph == 4) ? SIZE : 1); c++) begin
          for (int k = 0; k < d[ph-1] * PD; k++) begin
            r.st = 3'(ph);
            r.valve = valve_of(ph);
            r.pump = pat((k / PD) % 3);
            r.col = (ph == 4) ? (SIZE'(1) << c) : '0;
            r.busy = 1'b1; r.done = 1'b0; r.aborted = 1'b0;
            q.push_back(r);
          end
        end
      end
    end
    r = idle_rec();
    r.st = 3'd5; r.busy = 1'b1; r.done = 1'b1;
    q.push_back(r);
  endtask

  initial begin
    cur = idle_rec();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        cur = idle_rec();
      end else if (cur.st != 3'd0) begin
        if (abort) begin
          q.delete();
          cur = idle_rec();
          cur.aborted = 1'b1;
        end else if (q.size() > 0) begin
          cur = q.pop_front();
        end else begin
          cur = idle_rec();
        end
      end else if (start && !abort) begin
        build(int'(t_load), int'(t_lysis), int'(t_wash), int'(t_elute));
        cur = q.pop_front();
      end else begin
        cur = idle_rec();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && chk_en) begin
        chk("m_state",   32'(state),       32'(cur.st));
        chk("m_valve",   32'(valve),       32'(cur.valve));
        chk("m_pump",    32'(pump),        32'(cur.pump));
        chk("m_collect", 32'(collect_sel), 32'(cur.col));
        chk("m_busy",    32'(busy),        32'(cur.busy));
        chk("m_done",    32'(done),        32'(cur.done));
        chk("m_aborted", 32'(aborted),     32'(cur.aborted));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the edge that samples start (cycle offset k = 0).
  task automatic go(input int a, input int b, input int c, input int d);
    t_load = SW'(a); t_lysis = SW'(b); t_wash = SW'(c); t_elute = SW'(d);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " state"},   32'(state),       32'd0);
    chk({tag, " valve"},   32'(valve),       32'h7FF);
    chk({tag, " pump"},    32'(pump),        32'd0);
    chk({tag, " collect"}, 32'(collect_sel), 32'd0);
    chk({tag, " busy"},    32'(busy),        32'd0);
    chk({tag, " done"},    32'(done),        32'd0);
    chk({tag, " aborted"}, 32'(aborted),     32'd0);
  endtask

  initial begin
    int done_k, n_done, n_ch;
    logic seen_load, seen_wash, pump_nz;
    logic [SIZE-1:0] prev_col;

    #12;
    chk_reset_vals("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    step(); step();

    // Full run, all durations 2
    go(2, 2, 2, 2);
    done_k = -1; n_done = 0;
    for (int k = 0; k <= 129; k++) begin
      case (k)
        0:   begin chk("A load valve", 32'(valve), 32'h53F); chk("A load pump", 32'(pump), 32'h6); end
        8:   chk("A pump 2nd", 32'(pump), 32'h3);
        16:  begin chk("A lysis st", 32'(state), 32'd2); chk("A lysis valve", 32'(valve), 32'h5AE); end
        32:  begin chk("A wash st", 32'(state), 32'd3); chk("A wash valve", 32'(valve), 32'h59D); end
        48:  begin chk("A elute st", 32'(state), 32'd4); chk("A elute valve", 32'(valve), 32'h0FB);
                   chk("A col0", 32'(collect_sel), 32'h01); end
        64:  chk("A col1", 32'(collect_sel), 32'h02);
        112: chk("A col4", 32'(collect_sel), 32'h10);
        128: chk("A done st", 32'(state), 32'd5);
        129: begin chk("A idle st", 32'(state), 32'd0); chk("A idle busy", 32'(busy), 32'd0); end
        default: ;
      endcase
      if (done) begin n_done++; done_k = k; end
      step();
    end
    chk("A done cycle", 32'(done_k), 32'd128);
    chk("A done count", 32'(n_done), 32'd1);

    // Load and wash skipped
    go(0, 1, 0, 1);
    chk("B first st", 32'(state), 32'd2);
    done_k = -1; n_ch = 0; seen_load = 1'b0; seen_wash = 1'b0; prev_col = '0;
    for (int k = 0; k < 60; k++) begin
      if (valve == 11'h53F) seen_load = 1'b1;
      if (valve == 11'h59D) seen_wash = 1'b1;
      if (collect_sel != prev_col && collect_sel != '0) n_ch++;
      prev_col = collect_sel;
      if (done) done_k = k;
      step();
    end
    chk("B done cycle", 32'(done_k), 32'd48);
    chk("B channels", 32'(n_ch), 32'd5);
    chk("B load seen", 32'(seen_load), 32'd0);
    chk("B wash seen", 32'(seen_wash), 32'd0);

    // All durations zero
    go(0, 0, 0, 0);
    chk("C done st", 32'(state), 32'd5);
    chk("C done", 32'(done), 32'd1);
    pump_nz = (pump != 3'b000);
    step();
    chk("C idle st", 32'(state), 32'd0);
    chk("C done low", 32'(done), 32'd0);
    pump_nz = pump_nz | (pump != 3'b000);
    chk("C pump zero", 32'(pump_nz), 32'd0);
    step();

    // Pump sequence in a 4-stroke load
    go(4, 1, 0, 0);
    for (int k = 0; k < 44; k++) begin
      case (k)
        0:  chk("D pump0", 32'(pump), 32'h6);
        8:  chk("D pump1", 32'(pump), 32'h3);
        16: chk("D pump2", 32'(pump), 32'h5);
        24: chk("D pump3", 32'(pump), 32'h6);
        32: begin chk("D lysis st", 32'(state), 32'd2); chk("D lysis pump", 32'(pump), 32'h6); end
        default: ;
      endcase
      step();
    end

    // Abort on the final stroke of elute channel 2
    go(1, 1, 1, 1);
    n_done = 0;
    for (int k = 0; k < 52; k++) begin
      if (k == 47) begin
        chk("E col2", 32'(collect_sel), 32'h04);
        abort = 1'b1;
      end
      if (k == 48) begin
        abort = 1'b0;
        chk("E st", 32'(state), 32'd0);
        chk("E aborted", 32'(aborted), 32'd1);
        chk("E valve", 32'(valve), 32'h7FF);
        chk("E collect", 32'(collect_sel), 32'd0);
      end
      if (k == 49) chk("E aborted pulse", 32'(aborted), 32'd0);
      if (done) n_done++;
      step();
    end
    chk("E no done", 32'(n_done), 32'd0);

    // Async reset mid-wash, start while busy ignored
    go(2, 2, 2, 2);
    for (int k = 0; k < 43; k++) begin
      if (k >= 40) start = 1'b1;
      if (k == 41) chk("F busy start st", 32'(state), 32'd3);
      if (k < 42) step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("F async");
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) step();
    chk("F no resume", 32'(state), 32'd0);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      t_load  = SW'($urandom_range(0, 3));
      t_lysis = SW'($urandom_range(0, 3));
      t_wash  = SW'($urandom_range(0, 3));
      t_elute = SW'($urandom_range(0, 2));
      start   = ($urandom_range(0, 2) == 0);
      abort   = ($urandom_range(0, 149) == 0);
      step();
    end
    start = 1'b0; abort = 1'b0;
    for (int k = 0; k < 250; k++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
